// File: rtl/async_fifo_rd_stream.sv
// Read-side drain engine for the dual-clock FIFO: issues read strobes, absorbs the one-cycle
// read latency in a 3-entry prefetch buffer and emits a framed ready/valid stream.
module async_fifo_rd_stream #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             rst,
  input  logic             rd_clk,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  input  logic             flush,
  output logic [CNT_W-1:0] word_cnt,
  output logic             err
);

  localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);

  logic [WIDTH-1:0] mem_q [3];
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             pend_q;
  logic             flush_q;
  logic             err_q, err_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic pop;
  logic push;
  logic push_ok;
  logic full;
  logic discard;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A word returning in the flush cycle or the cycle after belongs to pre-flush traffic.
  assign discard = flush | flush_q;
  assign full    = (occ_q == 2'd3);
  assign pop     = m_valid & m_ready;
  assign push    = fifo_valid & ~discard;
  assign push_ok = push & (~full | pop);

  // Outstanding read counts against capacity, so the buffer can never overflow.
  assign fifo_rd_en = ~rst & ~fifo_empty & ~flush &
                      (({1'b0, occ_q} + {2'b00, pend_q}) <= 3'd2);

  assign m_valid  = (occ_q != 2'd0);
  assign m_last   = m_valid & (beat_q == LastBeat);
  assign word_cnt = word_cnt_q;
  assign err      = err_q;

  always_comb begin
    m_data = mem_q[0];
    case (rd_ptr_q)
      2'd1:    m_data = mem_q[1];
      2'd2:    m_data = mem_q[2];
      default: m_data = mem_q[0];
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    beat_d     = beat_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;

    if (fifo_valid && !pend_q && !discard) begin
      err_d = 1'b1;
    end
    if (push && full && !pop) begin
      err_d = 1'b1;
    end

    if (flush) begin
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      occ_d    = 2'd0;
      beat_d   = '0;
    end else begin
      if (pop) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        beat_d     = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
      if (push_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      occ_d = occ_q + {1'b0, push_ok} - {1'b0, pop};
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      pend_q     <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      pend_q     <= fifo_rd_en;
      flush_q    <= flush;
      err_q      <= err_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push_ok && (wr_ptr_q == 2'(i))) begin
          mem_q[i] <= fifo_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Randomised bench for async_fifo_rd_stream: a queue-based FIFO model feeds the DUT and a
// transaction-level scoreboard predicts the stream, framing, counters and error flag.
module tb_async_fifo_rd_stream;

  localparam int PKT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        m_ready;
  logic        inj_valid;
  logic [15:0] inj_data;

  logic        fifo_empty, fifo_valid, fifo_rd_en;
  logic [15:0] fifo_dout;
  logic [15:0] m_data, p1_data;
  logic        m_valid, m_last, err;
  logic        p1_rd_en, p1_valid, p1_last, p1_err;
  logic [31:0] word_cnt, p1_wc;

  // FIFO model
  logic [15:0] fq[$];
  logic        f_empty, f_valid;
  logic [15:0] f_dout = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_pulses = 0;
  int delivered = 0;

  // Scoreboard state
  logic [15:0] exp_q[$];
  int          m_beat;
  logic [31:0] m_wc;
  bit          m_err, m_pend, m_fl_prev;
  bit          vexp, hs, was_full;

  always #5 clk = ~clk;

  assign fifo_empty = f_empty;
  assign fifo_valid = f_valid | inj_valid;
  assign fifo_dout  = inj_valid ? inj_data : f_dout;

  async_fifo_rd_stream #(.WIDTH(16), .PKT_LEN(PKT), .CNT_W(32)) u_dut (
    .rst(rst), .rd_clk(clk), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .flush(flush), .word_cnt(word_cnt), .err(err)
  );

  async_fifo_rd_stream #(.WIDTH(16), .PKT_LEN(1), .CNT_W(32)) u_p1 (
    .rst(rst), .rd_clk(clk), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_dout(fifo_dout), .fifo_rd_en(p1_rd_en), .m_data(p1_data), .m_valid(p1_valid),
    .m_ready(m_ready), .m_last(p1_last), .flush(flush), .word_cnt(p1_wc), .err(p1_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      f_valid <= 1'b0;
      f_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && !f_empty && fq.size() != 0) begin
        f_dout  <= fq.pop_front();
        f_valid <= 1'b1;
      end else begin
        f_valid <= 1'b0;
      end
      f_empty <= (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_beat = 0; m_wc = '0; m_err = 0; m_pend = 0; m_fl_prev = 0;
    end else begin
      vexp = (exp_q.size() != 0);
      check_eq("m_valid", m_valid, vexp);
      check_eq("p1_valid", p1_valid, vexp);
      check_eq("p1_last", p1_last, vexp);
      if (vexp) begin
        check_eq("m_data", m_data, exp_q[0]);
        check_eq("p1_data", p1_data, exp_q[0]);
        check_eq("m_last", m_last, m_beat == PKT - 1);
      end else begin
        check_eq("m_last_idle", m_last, 0);
      end
      check_eq("rd_en", fifo_rd_en, !fifo_empty && !flush && (exp_q.size() + m_pend <= 2));
      check_eq("p1_rd_en", p1_rd_en, !fifo_empty && !flush && (exp_q.size() + m_pend <= 2));
      check_eq("word_cnt", word_cnt, m_wc);
      check_eq("p1_wc", p1_wc, m_wc);
      check_eq("err", err, m_err);
      check_eq("p1_err", p1_err, m_err);
      if (fifo_rd_en) rd_pulses++;

      hs = vexp && m_ready;
      if (flush) begin
        exp_q.delete();
        m_beat = 0;
      end else begin
        was_full = (exp_q.size() == 3);
        if (hs) begin
          void'(exp_q.pop_front());
          m_beat = (m_beat + 1) % PKT;
          m_wc++;
          delivered++;
        end
        if (fifo_valid && !m_fl_prev) begin
          if (!m_pend) m_err = 1;
          if (was_full && !hs) m_err = 1;
          else exp_q.push_back(fifo_dout);
        end
      end
      m_pend    = fifo_rd_en;
      m_fl_prev = flush;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int max_cycles);
    bit done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      step();
      done = (fq.size() == 0) && f_empty && !m_valid && !fifo_valid && !fifo_rd_en;
    end
    check_eq("drain", done, 1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_word_cnt", word_cnt, 0);
    check_eq("rst_err", err, 0);
  endtask

  initial begin
    int  base;
    int  pushed;
    bit  got;
    rst = 1'b0; flush = 1'b0; m_ready = 1'b0; inj_valid = 1'b0; inj_data = 16'h0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    rst = 1'b0;

    // Stream 1..20 with m_ready held high
    m_ready = 1'b1;
    for (int i = 1; i <= 20; i++) fq.push_back(16'(i));
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = m_valid;
    end
    check_eq("first_valid", got, 1);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check_eq("gapfree", m_valid, 1);
    end
    drain(50);
    check_eq("wc20", word_cnt, 20);

    // Backpressure: exactly three reads while stalled
    m_ready = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 10; i++) fq.push_back(16'h0100 + 16'(i));
    repeat (30) step();
    check_eq("bp_pulses", rd_pulses - base, 3);
    check_eq("bp_valid", m_valid, 1);
    check_eq("bp_data", m_data, 16'h0100);
    base = delivered;
    m_ready = 1'b1;
    drain(60);
    check_eq("bp_delivered", delivered - base, 10);

    // m_ready toggling every cycle
    base = delivered;
    for (int i = 0; i < 16; i++) fq.push_back(16'($urandom));
    for (int c = 0; c < 200 && (delivered - base) < 16; c++) begin
      step();
      m_ready = ~m_ready;
    end
    check_eq("toggle_delivered", delivered - base, 16);
    m_ready = 1'b1;
    drain(40);

    // Random pushes and random ready
    base = delivered;
    pushed = 0;
    for (int c = 0; c < 800 && (delivered - base) < 40; c++) begin
      if (pushed < 40 && ($urandom % 2) == 0) begin
        fq.push_back(16'($urandom));
        pushed++;
      end
      m_ready = 1'($urandom % 2);
      step();
    end
    check_eq("rand_delivered", delivered - base, 40);
    m_ready = 1'b1;
    drain(40);

    // Flush with two words buffered and one read in flight
    m_ready = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 12; i++) fq.push_back(16'h0200 + 16'(i));
    for (int c = 0; c < 20 && (rd_pulses - base) < 3; c++) step();
    check_eq("fl_pulses", rd_pulses - base, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check_eq("fl_empty", m_valid, 0);
    base = delivered;
    m_ready = 1'b1;
    drain(60);
    check_eq("fl_delivered", delivered - base, 9);

    // Unsolicited read data sets the sticky error
    step();
    inj_valid = 1'b1;
    inj_data  = 16'hBEEF;
    step();
    inj_valid = 1'b0;
    @(negedge clk);
    check_eq("err_set", err, 1);
    for (int i = 0; i < 10; i++) fq.push_back(16'($urandom));
    drain(60);
    check_eq("err_sticky", err, 1);

    // Mid-operation reset
    for (int i = 0; i < 6; i++) fq.push_back(16'h0300 + 16'(i));
    repeat (4) step();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) step();
    rst = 1'b0;
    step();
    check_eq("post_rst_wc", word_cnt, 0);
    check_eq("post_rst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
